timer_counter: RTL and testbench

Memory-mapped 32-bit down-counting timer on the CPU data bus, downstream of the pipeline's memory stage. It decodes word accesses in its 12-byte window (0x7f00–0x7f0b for TC1, 0x7f10–0x7f1b for TC2; the bridge strips the base). It drives one interrupt line into the CPU's `HWInt` vector (bit 2 for TC1, bit 3 for TC2). It supports one-shot and auto-reload modes under a four-state FSM.

---
 rtl/timer_counter.sv | 117 +++++++++++
 tb/tb_timer_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped 32-bit down-counting timer with one-shot/auto-reload FSM
module timer_counter #(
  parameter bit RELOAD_PULSE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  logic [1:0]  state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        irq_flag, flag_n;
  logic        ctrl_wr, preset_wr, stop, auto_reload;

  assign ctrl_wr     = we && (addr == 2'd0);
  assign preset_wr   = we && (addr == 2'd1);
  // A CTRL write clearing EN halts a running timer at the write edge itself.
  assign stop        = ctrl_wr && !wdata[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);

  always_comb begin
    case (addr)
      2'd0:    rdata = {28'b0, ctrl};
      2'd1:    rdata = preset;
      2'd2:    rdata = count;
      default: rdata = 32'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    ctrl_n   = ctrl;
    preset_n = preset;
    count_n  = count;
    flag_n   = irq_flag;

    if (ctrl_wr) begin
      ctrl_n = wdata[3:0];
      flag_n = 1'b0;
    end
    if (preset_wr) begin
      preset_n = wdata;
    end

    case (state)
      IDLE: begin
        if (ctrl[0] && !stop) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (stop || !ctrl[0]) begin
          state_n = IDLE;
        end else begin
          count_n = preset;
          state_n = CNT;
        end
      end
      CNT: begin
        if (stop || !ctrl[0]) begin
          state_n = IDLE;
        end else if (count != 32'd0) begin
          count_n = count - 32'd1;
        end else begin
          state_n = INT;
          flag_n  = 1'b1;
        end
      end
      default: begin
        if (stop) begin
          state_n = IDLE;
        end else if (auto_reload) begin
          state_n = LOAD;
          if (RELOAD_PULSE) begin
            flag_n = 1'b0;
          end
        end else begin
          state_n = IDLE;
          // Software's own CTRL write in this cycle keeps its EN value.
          if (!ctrl_wr) begin
            ctrl_n[0] = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= 4'b0;
      preset   <= 32'b0;
      count    <= 32'b0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      preset   <= preset_n;
      count    <= count_n;
      irq_flag <= flag_n;
      irq      <= flag_n & ctrl_n[3];
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter
module tb_timer_counter;

  localparam bit RELOAD_PULSE = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.RELOAD_PULSE(RELOAD_PULSE)) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Timeline model: a run is described by the edge at which COUNT is loaded
  // and the loaded value; everything else follows from elapsed edges.
  int          e = 0;
  int          t_load = 0;
  int          k = 0;
  bit          m_armed = 1'b0;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  logic [31:0] m_n = 32'd0;
  logic        m_flag = 1'b0;
  logic        m_irq = 1'b0;
  logic [3:0]  c0;
  logic [31:0] p0;
  bit          wr_c, wr_p, m_stop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e = 0; m_armed = 0; m_ctrl = 0; m_preset = 0; m_count = 0;
      m_n = 0; m_flag = 0; m_irq = 0;
    end else begin
      e = e + 1;
      c0 = m_ctrl;
      p0 = m_preset;
      wr_c = we && (addr == 2'd0);
      wr_p = we && (addr == 2'd1);
      m_stop = wr_c && !wdata[0];
      if (wr_c) begin
        m_ctrl = wdata[3:0];
        m_flag = 1'b0;
      end
      if (wr_p) m_preset = wdata;
      if (!m_armed) begin
        if (c0[0] && !m_stop) begin
          m_armed = 1'b1;
          t_load = e + 1;
        end
      end else if (m_stop) begin
        m_armed = 1'b0;
      end else if (e == t_load) begin
        m_n = p0;
        m_count = p0;
      end else begin
        k = e - t_load;
        if (longint'(k) <= longint'(m_n)) begin
          m_count = m_n - 32'(k);
        end else if (longint'(k) == longint'(m_n) + 1) begin
          m_flag = 1'b1;
        end else if (c0[2:1] == 2'b01) begin
          t_load = e + 1;
          if (RELOAD_PULSE) m_flag = 1'b0;
        end else begin
          m_armed = 1'b0;
          if (!wr_c) m_ctrl[0] = 1'b0;
        end
      end
      m_irq = m_flag & m_ctrl[3];
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("model_rdata", rdata, m_read(addr));
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, rdata, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, 32'd0);
    rd_chk("rst_count", 2'd2, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    // One-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    tick(); tick();
    rd_chk("os_cnt3", 2'd2, 32'd3);
    tick(); rd_chk("os_cnt2", 2'd2, 32'd2);
    tick(); rd_chk("os_cnt1", 2'd2, 32'd1);
    tick(); rd_chk("os_cnt0", 2'd2, 32'd0);
    chk("os_irq_pre", {31'b0, irq}, 32'd0);
    tick(); chk("os_irq_t6", {31'b0, irq}, 32'd1);
    tick(); rd_chk("os_ctrl_after", 2'd0, 32'h8);
    repeat (3) tick();
    chk("os_irq_held", {31'b0, irq}, 32'd1);
    wr(2'd0, 32'h0);
    chk("os_irq_cleared", {31'b0, irq}, 32'd0);

    // Reset mid-count
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    repeat (5) tick();
    rd_chk("rc_cnt5", 2'd2, 32'd5);
    reset = 1'b0;
    #1 chk("rc_irq_low", {31'b0, irq}, 32'd0);
    rd_chk("rc_ctrl0", 2'd0, 32'd0);
    rd_chk("rc_preset0", 2'd1, 32'd0);
    rd_chk("rc_count0", 2'd2, 32'd0);
    tick(); tick();
    reset = 1'b1;
    rd_chk("rr_ctrl0", 2'd0, 32'd0);
    rd_chk("rr_preset0", 2'd1, 32'd0);
    rd_chk("rr_count0", 2'd2, 32'd0);
    repeat (10) tick();
    chk("rr_no_irq", {31'b0, irq}, 32'd0);

    // Auto-reload, PRESET=2: pulses every 5 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    addr = 2'd2;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("ar_irq", {31'b0, irq}, (i >= 5 && (i - 5) % 5 == 0) ? 32'd1 : 32'd0);
    end
    wr(2'd0, 32'h0);

    // Masked expiry
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    repeat (4) tick();
    chk("mask_irq_exp", {31'b0, irq}, 32'd0);
    wr(2'd0, 32'h8);
    chk("mask_irq_after_im", {31'b0, irq}, 32'd0);
    tick(); tick();
    chk("mask_irq_later", {31'b0, irq}, 32'd0);

    // Disable mid-count
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    addr = 2'd2;
    repeat (6) tick();
    rd_chk("dis_cnt6", 2'd2, 32'd6);
    wr(2'd0, 32'h0);
    rd_chk("dis_frozen", 2'd2, 32'd6);
    repeat (3) tick();
    rd_chk("dis_frozen_later", 2'd2, 32'd6);
    wr(2'd0, 32'h1);
    rd_chk("re_pre_load", 2'd2, 32'd6);
    tick(); tick();
    rd_chk("re_loaded10", 2'd2, 32'd10);
    wr(2'd0, 32'h0);

    // PRESET and COUNT writes while counting
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h3);
    addr = 2'd2;
    tick(); tick();
    rd_chk("pw_cnt4", 2'd2, 32'd4);
    tick(); rd_chk("pw_cnt3", 2'd2, 32'd3);
    wr(2'd1, 32'd7);
    rd_chk("pw_running", 2'd2, 32'd2);
    wr(2'd2, 32'd99);
    rd_chk("cw_ignored", 2'd2, 32'd1);
    tick(); tick(); tick();
    rd_chk("pw_load_cycle", 2'd2, 32'd0);
    tick(); rd_chk("pw_reload7", 2'd2, 32'd7);
    rd_chk("pw_preset7", 2'd1, 32'd7);
    wr(2'd0, 32'h0);

    // PRESET=0 boundary
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    tick(); tick();
    chk("p0_irq_pre", {31'b0, irq}, 32'd0);
    tick(); chk("p0_irq", {31'b0, irq}, 32'd1);
    tick(); rd_chk("p0_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h0);

    // CTRL write during INT in one-shot keeps EN
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    addr = 2'd2;
    repeat (4) tick();
    chk("ic_irq_int", {31'b0, irq}, 32'd1);
    wr(2'd0, 32'h9);
    rd_chk("ic_ctrl_kept", 2'd0, 32'h9);
    chk("ic_irq_clr", {31'b0, irq}, 32'd0);
    tick(); tick();
    rd_chk("ic_reload", 2'd2, 32'd1);
    tick(); tick();
    chk("ic_irq_again", {31'b0, irq}, 32'd1);
    wr(2'd0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
